// File: rtl/delay_line_sched.sv
// delay_line_sched: round-robin scheduler that shares one fixed-latency delay line
// among M requesters. It grants one word per cycle into the line. A shadow valid/tag
// pipeline of the same depth routes each line output back to the requester that sent it.
// Optional feature: define DLS_FLUSH_EN to add a synchronous 'flush' input.
module delay_line_sched #(
    parameter int unsigned N     = 8,
    parameter int unsigned M     = 2,
    parameter int unsigned DELAY = 2
) (
    input  logic           clk,
    input  logic           rst_n,
`ifdef DLS_FLUSH_EN
    input  logic           flush,
`endif
    input  logic [M-1:0]   req_valid,
    input  logic [M*N-1:0] req_data,
    output logic [M-1:0]   req_ready,
    output logic [N-1:0]   line_idata,
    input  logic [N-1:0]   line_odata,
    output logic [M-1:0]   rsp_valid,
    output logic [N-1:0]   rsp_data,
    output logic [M-1:0]   busy,
    output logic           idle
);

    localparam int unsigned TW = (M > 1) ? $clog2(M) : 1;
    localparam int unsigned CW = (DELAY > 0) ? $clog2(DELAY + 1) : 1;

    if (DELAY < 1) begin : g_delay_check
        $error("delay_line_sched: DELAY must be at least 1");
    end
    if (M < 2 || M > 8) begin : g_m_check
        $error("delay_line_sched: M must be in 2..8");
    end

    logic          flush_w;
    logic [TW-1:0] rr_q;
    logic [TW-1:0] rr_next;
    logic [TW-1:0] grant_idx;
    logic          grant_any;
    logic          transfer;
    logic [DELAY-1:0] vld_q;
    logic [TW-1:0]    tag_q [DELAY];
    logic [CW-1:0]    cnt_q [M];

`ifdef DLS_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    // Round-robin search: first valid requester at or after the pointer, wrapping.
    always_comb begin
        int unsigned idx;
        grant_any = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int unsigned k = 0; k < M; k++) begin
            idx = (32'(rr_q) + k) % M;
            if (!grant_any && req_valid[TW'(idx)]) begin
                grant_any = 1'b1;
                grant_idx = TW'(idx);
            end
        end
    end

    assign transfer = grant_any & ~flush_w;
    assign rr_next  = (grant_idx == TW'(M - 1)) ? '0 : grant_idx + TW'(1);

    // One-hot grant and line input mux; the line sees zero when nothing is accepted.
    always_comb begin
        req_ready  = '0;
        line_idata = '0;
        if (transfer) begin
            req_ready[grant_idx] = 1'b1;
            line_idata           = req_data[grant_idx*N +: N];
        end
    end

    // Pointer moves past the winner only when a word is actually taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= '0;
        end else if (transfer) begin
            rr_q <= rr_next;
        end
    end

    // Shadow pipeline mirrors the delay line; it never stalls, flush drops all valids.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int unsigned k = 0; k < DELAY; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            vld_q[0] <= transfer;
            tag_q[0] <= grant_idx;
            for (int unsigned k = 1; k < DELAY; k++) begin
                vld_q[k] <= vld_q[k-1];
                tag_q[k] <= tag_q[k-1];
            end
            if (flush_w) begin
                vld_q <= '0;
            end
        end
    end

    // Route the line output to its originator.
    always_comb begin
        rsp_valid = '0;
        if (vld_q[DELAY-1]) begin
            rsp_valid[tag_q[DELAY-1]] = 1'b1;
        end
    end

    assign rsp_data = line_odata;

    // Per-requester in-flight count; simultaneous accept and response cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < M; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < M; i++) begin
                if (flush_w) begin
                    cnt_q[i] <= '0;
                end else if (req_ready[i] && !rsp_valid[i]) begin
                    cnt_q[i] <= cnt_q[i] + CW'(1);
                end else if (!req_ready[i] && rsp_valid[i]) begin
                    cnt_q[i] <= cnt_q[i] - CW'(1);
                end
            end
        end
    end

    // Status flags derived from the counters.
    always_comb begin
        for (int unsigned i = 0; i < M; i++) begin
            busy[i] = (cnt_q[i] != '0);
        end
        idle = ~|busy;
    end

endmodule

// File: tb/tb_delay_line_sched.sv
// Bench for delay_line_sched (M=2, N=8, DELAY=2). Models the delay line and checks
// the DUT against a transaction-level reference: a list of in-flight words with due cycles.
module tb_delay_line_sched;

    localparam int N     = 8;
    localparam int M     = 2;
    localparam int DELAY = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [M-1:0]  req_valid;
    logic [M*N-1:0] req_data;
    logic [M-1:0]  req_ready;
    logic [N-1:0]  line_idata;
    logic [N-1:0]  line_odata;
    logic [M-1:0]  rsp_valid;
    logic [N-1:0]  rsp_data;
    logic [M-1:0]  busy;
    logic          idle;
`ifdef DLS_FLUSH_EN
    logic          flush;
`endif

    always #5 clk = ~clk;

    delay_line_sched #(.N(N), .M(M), .DELAY(DELAY)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef DLS_FLUSH_EN
        .flush      (flush),
`endif
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .line_idata (line_idata),
        .line_odata (line_odata),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .busy       (busy),
        .idle       (idle)
    );

    // Delay line model: no reset, no enable.
    logic [N-1:0] dl [DELAY];
    always @(posedge clk) begin
        dl[0] <= line_idata;
        for (int k = 1; k < DELAY; k++) dl[k] <= dl[k-1];
    end
    assign line_odata = dl[DELAY-1];

    typedef struct {
        int         due;
        int         id;
        logic [7:0] data;
    } item_t;

    item_t q[$];
    int    cyc    = 0;
    int    rr_m   = 0;
    int    n_tests = 0;
    int    n_fail  = 0;

    // Drive one cycle, compare against the model, then advance the model and the clock.
    task automatic cycle_chk(input logic [1:0] v, input logic [15:0] d, input logic fl,
                             input string nm);
        int         g;
        logic [1:0] e_ready;
        logic [1:0] e_rsp;
        logic [1:0] e_busy;
        logic [7:0] e_data;
        logic       e_idle;
        item_t      nq[$];
        item_t      it;
        req_valid = v;
        req_data  = d;
`ifdef DLS_FLUSH_EN
        flush = fl;
`endif
        #1;
        g = -1;
        if (!fl) begin
            for (int k = 0; k < M; k++) begin
                int idx;
                idx = (rr_m + k) % M;
                if (g < 0 && v[idx]) g = idx;
            end
        end
        e_ready = '0;
        if (g >= 0) e_ready[g] = 1'b1;
        e_rsp  = '0;
        e_busy = '0;
        e_data = '0;
        foreach (q[i]) begin
            e_busy[q[i].id] = 1'b1;
            if (q[i].due == cyc) begin
                e_rsp[q[i].id] = 1'b1;
                e_data         = q[i].data;
            end
        end
        e_idle = (q.size() == 0);

        n_tests++;
        if (req_ready !== e_ready) begin
            n_fail++;
            $display("FAIL %s cyc=%0d req_ready got %b expected %b", nm, cyc, req_ready, e_ready);
        end
        n_tests++;
        if (rsp_valid !== e_rsp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d rsp_valid got %b expected %b", nm, cyc, rsp_valid, e_rsp);
        end
        if (e_rsp != 2'b00) begin
            n_tests++;
            if (rsp_data !== e_data) begin
                n_fail++;
                $display("FAIL %s cyc=%0d rsp_data got %h expected %h", nm, cyc, rsp_data, e_data);
            end
        end
        n_tests++;
        if (busy !== e_busy) begin
            n_fail++;
            $display("FAIL %s cyc=%0d busy got %b expected %b", nm, cyc, busy, e_busy);
        end
        n_tests++;
        if (idle !== e_idle) begin
            n_fail++;
            $display("FAIL %s cyc=%0d idle got %b expected %b", nm, cyc, idle, e_idle);
        end
        if (g >= 0) begin
            n_tests++;
            if (line_idata !== d[g*8 +: 8]) begin
                n_fail++;
                $display("FAIL %s cyc=%0d line_idata got %h expected %h", nm, cyc, line_idata,
                         d[g*8 +: 8]);
            end
        end else if (v == 2'b00) begin
            n_tests++;
            if (line_idata !== 8'h00) begin
                n_fail++;
                $display("FAIL %s cyc=%0d line_idata got %h expected 00", nm, cyc, line_idata);
            end
        end

        foreach (q[i]) if (q[i].due != cyc) nq.push_back(q[i]);
        q = nq;
        if (fl) q.delete();
        if (g >= 0) begin
            it.due  = cyc + DELAY;
            it.id   = g;
            it.data = d[g*8 +: 8];
            q.push_back(it);
            rr_m = (g + 1) % M;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic chk_in_reset(input string nm);
        #1;
        n_tests++;
        if (rsp_valid !== 2'b00 || idle !== 1'b1 || busy !== 2'b00) begin
            n_fail++;
            $display("FAIL %s rsp_valid/busy/idle got %b/%b/%b expected 00/00/1", nm,
                     rsp_valid, busy, idle);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
`ifdef DLS_FLUSH_EN
        flush = 1'b0;
`endif
        chk_in_reset("reset_hold");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        rr_m = 0;
        for (int i = 0; i < 10; i++) cycle_chk(2'b00, 16'h0000, 1'b0, "reset_idle");
    endtask

    task automatic test_single();
        cycle_chk(2'b01, 16'hEE11, 1'b0, "single_acc");
        for (int i = 0; i < 4; i++) cycle_chk(2'b00, 16'h0000, 1'b0, "single_rsp");
    endtask

    task automatic test_alternate();
        for (int i = 0; i < 8; i++)
            cycle_chk(2'b11, {8'hB0 + 8'(i), 8'hA0 + 8'(i)}, 1'b0, "alternate");
        for (int i = 0; i < 3; i++) cycle_chk(2'b00, 16'h0000, 1'b0, "alternate_drain");
    endtask

    task automatic test_stream();
        for (int i = 1; i <= 4; i++) cycle_chk(2'b10, {8'(i), 8'h77}, 1'b0, "stream");
        for (int i = 0; i < 3; i++) cycle_chk(2'b00, 16'h0000, 1'b0, "stream_drain");
    endtask

    task automatic test_reset_mid();
        cycle_chk(2'b10, 16'h2200, 1'b0, "rstmid_acc");
        cycle_chk(2'b01, 16'h0021, 1'b0, "rstmid_acc");
        rst_n     = 1'b0;
        req_valid = '0;
        chk_in_reset("rstmid_hold");
        q.delete();
        rr_m = 0;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cycle_chk(2'b00, 16'h0000, 1'b0, "rstmid_quiet");
        cycle_chk(2'b11, 16'h3231, 1'b0, "rstmid_ptr");
        for (int i = 0; i < 3; i++) cycle_chk(2'b00, 16'h0000, 1'b0, "rstmid_drain");
    endtask

`ifdef DLS_FLUSH_EN
    task automatic test_flush();
        cycle_chk(2'b01, 16'h0055, 1'b0, "flush_acc");
        cycle_chk(2'b01, 16'h0056, 1'b1, "flush_cycle");
        for (int i = 0; i < 3; i++) cycle_chk(2'b00, 16'h0000, 1'b0, "flush_after");
    endtask
`endif

    task automatic test_random();
        logic [1:0]  v;
        logic [15:0] d;
        logic        fl;
        for (int i = 0; i < 400; i++) begin
            v  = 2'($urandom_range(0, 3));
            d  = 16'($urandom);
            fl = 1'b0;
`ifdef DLS_FLUSH_EN
            fl = ($urandom_range(0, 15) == 0);
`endif
            cycle_chk(v, d, fl, "random");
        end
        for (int i = 0; i < 3; i++) cycle_chk(2'b00, 16'h0000, 1'b0, "random_drain");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_stream();
        test_reset_mid();
`ifdef DLS_FLUSH_EN
        test_flush();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
